// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA operand fetch stage: default word/key widths,
// default SRAM base addresses, the loader FSM state encoding and the tag that
// follows each issued SRAM read so the returning word lands in the right
// operand register.
// -----------------------------------------------------------------------------
package rsa_pkg;

    localparam int WORD_W    = 32;
    localparam int KEY_W     = 2048;
    localparam int KEY_WORDS = KEY_W / WORD_W;
    localparam int ADDR_W    = 8;

    localparam int N_BASE    = 0;
    localparam int KEY_BASE  = 64;
    localparam int TEXT_BASE = 128;

    typedef enum logic [2:0] {
        RSA_ST_IDLE   = 3'd0,
        RSA_ST_LOAD_N = 3'd1,
        RSA_ST_LOAD_K = 3'd2,
        RSA_ST_LOAD_T = 3'd3,
        RSA_ST_DRAIN  = 3'd4,
        RSA_ST_DONE   = 3'd5
    } rsa_state_e;

    typedef enum logic [1:0] {
        RSA_TAG_NONE = 2'd0,
        RSA_TAG_N    = 2'd1,
        RSA_TAG_K    = 2'd2,
        RSA_TAG_T    = 2'd3
    } rsa_tag_e;

endpackage : rsa_pkg

// File: rtl/rsa_wide_shreg.sv
// -----------------------------------------------------------------------------
// rsa_wide_shreg
// KEY_W-bit shift-in register. Each load shifts the incoming word into the top
// and everything else down by one word, so after KEY_W/WORD_W loads the first
// word received sits in the least-significant position.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clr    in   synchronous clear (wins over i_load)
//   i_load   in   shift i_data in
//   i_data   in   WORD_W  incoming word
//   o_q      out  KEY_W   register contents
// -----------------------------------------------------------------------------
module rsa_wide_shreg #(
    parameter int KEY_W  = rsa_pkg::KEY_W,
    parameter int WORD_W = rsa_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    output logic [KEY_W-1:0]  o_q
);

    logic [KEY_W-1:0] r_q;

    // Shift register: clear, shift a word in from the top, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {KEY_W{1'b0}};
        end else if (i_clr) begin
            r_q <= {KEY_W{1'b0}};
        end else if (i_load) begin
            r_q <= {i_data, r_q[KEY_W-1:WORD_W]};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule : rsa_wide_shreg

// File: rtl/rsa_operand_loader.sv
// -----------------------------------------------------------------------------
// rsa_operand_loader
// Fetches modulus N, key and the text word from a synchronous-read SRAM, one
// word per cycle, and assembles them into the operand registers consumed by the
// RSA controller / Montgomery multiplier.
//
// Optional feature: define RSA_LOADER_NCHECK_EN to reject an even modulus
// (n_err=1, valid stays 0). Without it n_err is constant 0.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a full load (honoured only in IDLE)
//   en       out  SRAM read enable (registered)
//   addr     out  ADDR_W SRAM read address (registered)
//   data     in   WORD_W SRAM read data, valid the cycle after en
//   busy     out  load in progress
//   done     out  one-cycle pulse at load completion
//   valid    out  operands hold a complete, accepted load
//   n_err    out  modulus rejected
//   in_N     out  KEY_W modulus
//   in_key   out  KEY_W exponent
//   in_text  out  WORD_W text word
// -----------------------------------------------------------------------------
module rsa_operand_loader #(
    parameter int WORD_W    = rsa_pkg::WORD_W,
    parameter int KEY_W     = rsa_pkg::KEY_W,
    parameter int ADDR_W    = rsa_pkg::ADDR_W,
    parameter int N_BASE    = rsa_pkg::N_BASE,
    parameter int KEY_BASE  = rsa_pkg::KEY_BASE,
    parameter int TEXT_BASE = rsa_pkg::TEXT_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              n_err,
    output logic [KEY_W-1:0]  in_N,
    output logic [KEY_W-1:0]  in_key,
    output logic [WORD_W-1:0] in_text
);

    import rsa_pkg::*;

    localparam int LD_WORDS = KEY_W / WORD_W;
    localparam int CNT_W    = (LD_WORDS > 1) ? $clog2(LD_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE   = RSA_ST_IDLE;
    localparam logic [2:0] ST_LOAD_N = RSA_ST_LOAD_N;
    localparam logic [2:0] ST_LOAD_K = RSA_ST_LOAD_K;
    localparam logic [2:0] ST_LOAD_T = RSA_ST_LOAD_T;
    localparam logic [2:0] ST_DRAIN  = RSA_ST_DRAIN;
    localparam logic [2:0] ST_DONE   = RSA_ST_DONE;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic              r_nerr;
    rsa_tag_e          r_tag;
    logic [WORD_W-1:0] r_text;

    logic [2:0]        w_nstate;
    logic [CNT_W-1:0]  w_ncnt;
    logic              w_accept;
    logic              w_nen;
    logic [ADDR_W-1:0] w_naddr;
    logic              w_nbusy;
    rsa_tag_e          w_tag;
    logic              w_cap_n;
    logic              w_cap_k;
    logic              w_cap_t;
    logic [KEY_W-1:0]  w_n_q;
    logic [KEY_W-1:0]  w_key_q;

    // Next-state and word-counter logic; start is only honoured in IDLE.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nstate = ST_LOAD_N;
                    w_ncnt   = {CNT_W{1'b0}};
                    w_accept = 1'b1;
                end else begin
                    w_nstate = ST_IDLE;
                end
            end
            ST_LOAD_N: begin
                if (r_cnt == CNT_LAST) begin
                    w_nstate = ST_LOAD_K;
                    w_ncnt   = {CNT_W{1'b0}};
                end else begin
                    w_ncnt = r_cnt + CNT_ONE;
                end
            end
            ST_LOAD_K: begin
                if (r_cnt == CNT_LAST) begin
                    w_nstate = ST_LOAD_T;
                    w_ncnt   = {CNT_W{1'b0}};
                end else begin
                    w_ncnt = r_cnt + CNT_ONE;
                end
            end
            ST_LOAD_T: w_nstate = ST_DRAIN;
            ST_DRAIN:  w_nstate = ST_DONE;
            ST_DONE:   w_nstate = ST_IDLE;
            default:   w_nstate = ST_IDLE;
        endcase
    end

    // SRAM port values for the upcoming state, so en/addr can be registered
    // yet line up with the state that issues the read.
    always_comb begin
        w_nen   = 1'b0;
        w_naddr = {ADDR_W{1'b0}};
        w_nbusy = 1'b0;
        case (w_nstate)
            ST_LOAD_N: begin
                w_nen   = 1'b1;
                w_naddr = ADDR_W'(N_BASE) + ADDR_W'(w_ncnt);
                w_nbusy = 1'b1;
            end
            ST_LOAD_K: begin
                w_nen   = 1'b1;
                w_naddr = ADDR_W'(KEY_BASE) + ADDR_W'(w_ncnt);
                w_nbusy = 1'b1;
            end
            ST_LOAD_T: begin
                w_nen   = 1'b1;
                w_naddr = ADDR_W'(TEXT_BASE);
                w_nbusy = 1'b1;
            end
            ST_DRAIN: begin
                w_nbusy = 1'b1;
            end
            default: begin
                w_nen = 1'b0;
            end
        endcase
    end

    // Destination of the read being issued in the current state.
    always_comb begin
        w_tag = RSA_TAG_NONE;
        case (r_state)
            ST_LOAD_N: w_tag = RSA_TAG_N;
            ST_LOAD_K: w_tag = RSA_TAG_K;
            ST_LOAD_T: w_tag = RSA_TAG_T;
            default:   w_tag = RSA_TAG_NONE;
        endcase
    end

    // FSM, counter, registered SRAM port, status strobes and the read tag that
    // trails each issued read by one cycle (matching the SRAM read latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_en    <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tag   <= RSA_TAG_NONE;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_en    <= w_nen;
            r_addr  <= w_naddr;
            r_busy  <= w_nbusy;
            r_done  <= (w_nstate == ST_DONE);
            r_tag   <= w_tag;
        end
    end

    assign w_cap_n = (r_tag == RSA_TAG_N);
    assign w_cap_k = (r_tag == RSA_TAG_K);
    assign w_cap_t = (r_tag == RSA_TAG_T);

    rsa_wide_shreg #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
    ) u_shreg_n (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_load (w_cap_n),
        .i_data (data),
        .o_q    (w_n_q)
    );

    rsa_wide_shreg #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
    ) u_shreg_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_load (w_cap_k),
        .i_data (data),
        .o_q    (w_key_q)
    );

    // Text word capture; cleared when a new load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_text <= {WORD_W{1'b0}};
        end else if (w_accept) begin
            r_text <= {WORD_W{1'b0}};
        end else if (w_cap_t) begin
            r_text <= data;
        end else begin
            r_text <= r_text;
        end
    end

    // valid / n_err: cleared on an accepted start, resolved on the DRAIN->DONE
    // edge so both are visible together with the done pulse. N is complete
    // long before this edge, so its LSB is safe to inspect here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_nerr  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b0;
            r_nerr  <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
`ifdef RSA_LOADER_NCHECK_EN
            if (w_n_q[0] == 1'b0) begin
                r_valid <= 1'b0;
                r_nerr  <= 1'b1;
            end else begin
                r_valid <= 1'b1;
                r_nerr  <= 1'b0;
            end
`else
            r_valid <= 1'b1;
            r_nerr  <= 1'b0;
`endif
        end else begin
            r_valid <= r_valid;
            r_nerr  <= r_nerr;
        end
    end

    assign en      = r_en;
    assign addr    = r_addr;
    assign busy    = r_busy;
    assign done    = r_done;
    assign valid   = r_valid;
    assign n_err   = r_nerr;
    assign in_N    = w_n_q;
    assign in_key  = w_key_q;
    assign in_text = r_text;

endmodule : rsa_operand_loader
